// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, shifts a byte out on device
// clock falls with odd parity and stop, then samples the device ack.
// Start and transfer phases are guarded by timeouts.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES       = 5000,
   parameter int START_TIMEOUT_CYCLES = 750000,
   parameter int XFER_TIMEOUT_CYCLES  = 100000,
   parameter int FILTER_CYCLES        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   output logic       tx_done,
   output logic       tx_ack_err,
   output logic       tx_timeout
);

   // One counter width covers inhibit, start timer and transfer timer.
   localparam int CNT_A = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                          START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
   localparam int CNT_TOP = (CNT_A > INHIBIT_CYCLES) ? CNT_A : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_TOP + 1);
   localparam int FILT_W  = $clog2(FILTER_CYCLES + 1);

   localparam logic [CNT_W-1:0]  INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  INH_PRE    = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
   localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(FILTER_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_SEND,
      S_ACK,
      S_RELEASE,
      S_DONE
   } state_t;

   // Input conditioning
   logic              clk_meta_q, clk_meta_d;
   logic              clk_sync_q, clk_sync_d;
   logic              data_meta_q, data_meta_d;
   logic              data_sync_q, data_sync_d;
   logic              filt_q, filt_d;
   logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
   logic              fall;

   // Transmit datapath and control
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  xfer_q, xfer_d;
   logic [3:0]        idx_q, idx_d;
   logic [9:0]        shift_q, shift_d;
   logic              clk_drv_q, clk_drv_d;
   logic              data_drv_q, data_drv_d;
   logic              ack_err_q, ack_err_d;
   logic              timeout_q, timeout_d;
   logic              go_timeout;

   // Two-stage synchronisers for both raw pins.
   always_comb begin
      clk_meta_d  = ps2_clk_in;
      clk_sync_d  = clk_meta_q;
      data_meta_d = ps2_data_in;
      data_sync_d = data_meta_q;
   end

   // Clock deglitch: follow the synchronised clock only after it has
   // disagreed with the filtered value for FILTER_CYCLES samples in a row.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      fall       = 1'b0;
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d = clk_sync_q;
            fall   = filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   // Transaction FSM: next state, counters, shift register and line drives.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      xfer_d     = xfer_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      clk_drv_d  = clk_drv_q;
      data_drv_d = data_drv_q;
      ack_err_d  = ack_err_q;
      timeout_d  = timeout_q;
      go_timeout = 1'b0;

      case (state_q)
         S_IDLE: begin
            clk_drv_d  = 1'b0;
            data_drv_d = 1'b0;
            if (tx_valid) begin
               // Stop bit on top, odd parity over the byte, data LSB first.
               shift_d    = {1'b1, ~^tx_data, tx_data};
               cnt_d      = '0;
               ack_err_d  = 1'b0;
               timeout_d  = 1'b0;
               clk_drv_d  = 1'b1;
               data_drv_d = (INHIBIT_CYCLES <= 1);
               state_d    = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            clk_drv_d = 1'b1;
            if (cnt_q == INH_LAST) begin
               // Release clock with data already low: request-to-send.
               clk_drv_d  = 1'b0;
               data_drv_d = 1'b1;
               cnt_d      = '0;
               xfer_d     = '0;
               idx_d      = '0;
               state_d    = S_SEND;
            end else begin
               cnt_d = cnt_q + 1'b1;
               // Start bit goes low one cycle before the clock is released.
               if (cnt_q == INH_PRE) begin
                  data_drv_d = 1'b1;
               end
            end
         end

         S_SEND: begin
            if (idx_q == 4'd0) begin
               // Waiting for the device to begin clocking.
               if (fall) begin
                  data_drv_d = ~shift_q[0];
                  idx_d      = 4'd1;
                  xfer_d     = '0;
               end else if (cnt_q == START_LAST) begin
                  go_timeout = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (xfer_q == XFER_LAST) begin
               go_timeout = 1'b1;
            end else begin
               xfer_d = xfer_q + 1'b1;
               if (fall) begin
                  data_drv_d = ~shift_q[idx_q];
                  idx_d      = idx_q + 4'd1;
                  if (idx_q == 4'd9) begin
                     state_d = S_ACK;
                  end
               end
            end
         end

         S_ACK: begin
            data_drv_d = 1'b0;
            clk_drv_d  = 1'b0;
            if (xfer_q == XFER_LAST) begin
               go_timeout = 1'b1;
            end else begin
               xfer_d = xfer_q + 1'b1;
               if (fall) begin
                  // Device pulls data low to acknowledge.
                  ack_err_d = data_sync_q;
                  state_d   = S_RELEASE;
               end
            end
         end

         S_RELEASE: begin
            clk_drv_d  = 1'b0;
            data_drv_d = 1'b0;
            if (filt_q && data_sync_q) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            clk_drv_d  = 1'b0;
            data_drv_d = 1'b0;
            state_d    = S_IDLE;
         end

         default: begin
            clk_drv_d  = 1'b0;
            data_drv_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase

      // Any expired timer drops both lines at once and reports a timeout.
      if (go_timeout) begin
         clk_drv_d  = 1'b0;
         data_drv_d = 1'b0;
         timeout_d  = 1'b1;
         ack_err_d  = 1'b0;
         state_d    = S_DONE;
      end
   end

   // State and datapath registers; reset releases both bus lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         xfer_q      <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         clk_drv_q   <= 1'b0;
         data_drv_q  <= 1'b0;
         ack_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         clk_meta_q  <= clk_meta_d;
         clk_sync_q  <= clk_sync_d;
         data_meta_q <= data_meta_d;
         data_sync_q <= data_sync_d;
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         xfer_q      <= xfer_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         clk_drv_q   <= clk_drv_d;
         data_drv_q  <= data_drv_d;
         ack_err_q   <= ack_err_d;
         timeout_q   <= timeout_d;
      end
   end

   // Status outputs; error flags are only visible alongside tx_done.
   always_comb begin
      tx_ready           = (state_q == S_IDLE);
      busy               = (state_q != S_IDLE);
      tx_done            = (state_q == S_DONE);
      tx_ack_err         = (state_q == S_DONE) & ack_err_q;
      tx_timeout         = (state_q == S_DONE) & timeout_q;
      ps2_clk_drive_low  = clk_drv_q;
      ps2_data_drive_low = data_drv_q;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a behavioural PS/2 device
// on wired-AND bus lines and a scoreboard of bytes sent.
module tb_ps2_host_tx;

   localparam int INH      = 20;
   localparam int START_TO = 400;
   localparam int XFER_TO  = 2000;
   localparam int FILT     = 2;
   localparam int HALF     = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, busy, tx_done, tx_ack_err, tx_timeout;
   logic       ps2_clk_drive_low, ps2_data_drive_low;
   logic       ps2_clk_in, ps2_data_in;

   logic dev_clk = 1'b1;
   logic dev_data_low = 1'b0;
   logic glitch = 1'b0;

   // Open-drain bus: either side can pull a line low.
   assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low & ~glitch;
   assign ps2_data_in = ~ps2_data_drive_low & ~dev_data_low;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES      (INH),
      .START_TIMEOUT_CYCLES(START_TO),
      .XFER_TIMEOUT_CYCLES (XFER_TO),
      .FILTER_CYCLES       (FILT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .busy              (busy),
      .ps2_clk_in        (ps2_clk_in),
      .ps2_data_in       (ps2_data_in),
      .ps2_clk_drive_low (ps2_clk_drive_low),
      .ps2_data_drive_low(ps2_data_drive_low),
      .tx_done           (tx_done),
      .tx_ack_err        (tx_ack_err),
      .tx_timeout        (tx_timeout)
   );

   int         n_checks = 0;
   int         n_fail = 0;
   int         done_count = 0;
   logic [7:0] exp_q[$];
   logic [1:0] done_q[$];
   logic       obs_bits[$];

   int   dev_inh_len;
   int   dev_inh_data;
   logic dev_start_bit;
   logic dev_ok;
   int   wg;

   // Expected data_drive_low after fall i+1: inverted data bit, then
   // inverted odd parity, then stop (released).
   function automatic logic exp_drive(input logic [7:0] d, input int i);
      if (i < 8) return ~d[i];
      if (i == 8) return ^d;
      return 1'b0;
   endfunction

   // Record every tx_done; flags must stay low between pulses.
   always @(negedge clk) begin
      if (tx_done === 1'b1) begin
         done_q.push_back({tx_ack_err, tx_timeout});
         done_count++;
         $display("tx_done ack_err=%0b timeout=%0b at %0t", tx_ack_err, tx_timeout, $time);
      end else if (!rst) begin
         n_checks++;
         if (tx_ack_err !== 1'b0 || tx_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_without_done: ack_err=%b timeout=%b expected 0 0", tx_ack_err, tx_timeout);
         end
      end
   end

   // Device model: measure inhibit, then clock n_falls falls, recording
   // data_drive_low late in each low phase. Optional 1-cycle glitch in
   // the high phase after fall glitch_after. Ack driven before fall 11.
   task automatic device_frame(input logic ack, input int glitch_after, input int n_falls);
      int guard;
      obs_bits.delete();
      dev_inh_len = 0;
      dev_inh_data = 0;
      dev_start_bit = 1'b0;
      dev_ok = 1'b0;
      guard = 0;
      while (ps2_clk_drive_low !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) return;
      while (ps2_clk_drive_low === 1'b1 && dev_inh_len < 1000) begin
         if (ps2_data_drive_low === 1'b1) dev_inh_data++;
         dev_inh_len++;
         @(negedge clk);
      end
      dev_start_bit = ps2_data_drive_low;
      repeat (10) @(negedge clk);
      for (int k = 1; k <= n_falls; k++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (k <= 10) obs_bits.push_back(ps2_data_drive_low);
         if (k == n_falls && n_falls < 11) begin
            dev_ok = 1'b1;
            return;
         end
         dev_clk = 1'b1;
         if (k == 10) dev_data_low = ack;
         for (int c = 0; c < HALF; c++) begin
            glitch = (k == glitch_after && c == 10);
            @(negedge clk);
         end
         glitch = 1'b0;
      end
      dev_data_low = 1'b0;
      dev_ok = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (ps2_clk_drive_low !== 1'b0) begin n_fail++; $display("FAIL reset_clk_drive: got %b expected 0", ps2_clk_drive_low); end
      n_checks++; if (ps2_data_drive_low !== 1'b0) begin n_fail++; $display("FAIL reset_data_drive: got %b expected 0", ps2_data_drive_low); end
      n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: ready=%b busy=%b expected 1 0", tx_ready, busy); end
      $display("test_reset complete");
   endtask

   // One full frame: send d, device clocks 11 falls, acks if ack=1.
   task automatic test_frame(input logic [7:0] d, input logic ack, input int glitch_after, input string name);
      logic [7:0] e;
      logic [1:0] f;
      int guard;
      n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b expected 1", name, tx_ready); end
      tx_data = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      exp_q.push_back(d);
      device_frame(ack, glitch_after, 11);
      n_checks++; if (dev_ok !== 1'b1) begin n_fail++; $display("FAIL %s_device: frame got %b expected 1", name, dev_ok); end
      n_checks++; if (dev_inh_len != INH) begin n_fail++; $display("FAIL %s_inhibit_len: got %0d expected %0d", name, dev_inh_len, INH); end
      n_checks++; if (dev_inh_data != 1) begin n_fail++; $display("FAIL %s_inhibit_data_cycles: got %0d expected 1", name, dev_inh_data); end
      n_checks++; if (dev_start_bit !== 1'b1) begin n_fail++; $display("FAIL %s_start_bit: got %b expected 1", name, dev_start_bit); end
      e = exp_q.pop_front();
      n_checks++;
      if (obs_bits.size() != 10) begin
         n_fail++;
         $display("FAIL %s_bit_count: got %0d expected 10", name, obs_bits.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (i > 0) n_checks++;
            if (obs_bits[i] !== exp_drive(e, i)) begin
               n_fail++;
               $display("FAIL %s_fall%0d: data_drive_low got %b expected %b", name, i + 1, obs_bits[i], exp_drive(e, i));
            end
         end
      end
      guard = 0;
      while (done_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
      n_checks++;
      if (done_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s_done: got no tx_done expected one", name);
      end else begin
         f = done_q.pop_front();
         n_checks++;
         if (f !== {~ack, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_flags: got ack_err,timeout=%b expected %b", name, f, {~ack, 1'b0});
         end
      end
      repeat (20) @(negedge clk);
      n_checks++; if (done_q.size() != 0) begin n_fail++; $display("FAIL %s_single_done: got %0d extra pulses expected 0", name, done_q.size()); end
      done_q.delete();
      $display("frame %s byte=%h ack=%0b checked", name, d, ack);
   endtask

   task automatic test_start_timeout;
      int guard;
      int n;
      logic [7:0] e;
      logic [1:0] f;
      tx_data = 8'hF3;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      exp_q.push_back(8'hF3);
      guard = 0;
      while (ps2_clk_drive_low === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      n = 0;
      while (ps2_data_drive_low === 1'b1 && n < 1000) begin @(negedge clk); n++; end
      n_checks++; if (n < START_TO - 1 || n > START_TO + 1) begin n_fail++; $display("FAIL start_timeout_cycles: got %0d expected %0d", n, START_TO); end
      n_checks++; if (ps2_clk_drive_low !== 1'b0) begin n_fail++; $display("FAIL start_timeout_clk_released: got %b expected 0", ps2_clk_drive_low); end
      guard = 0;
      while (done_q.size() == 0 && guard < 20) begin @(negedge clk); guard++; end
      n_checks++;
      if (done_q.size() == 0) begin
         n_fail++;
         $display("FAIL start_timeout_done: got no tx_done expected one");
      end else begin
         f = done_q.pop_front();
         n_checks++; if (f !== 2'b01) begin n_fail++; $display("FAIL start_timeout_flags: got ack_err,timeout=%b expected 01", f); end
      end
      e = exp_q.pop_front();
      repeat (5) @(negedge clk);
      n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL start_timeout_idle: tx_ready got %b expected 1", tx_ready); end
      $display("start timeout byte=%h measured %0d cycles", e, n);
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] e;
      int base;
      tx_data = 8'h5A;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      exp_q.push_back(8'h5A);
      device_frame(1'b1, 0, 5);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_bits.size() != 5) begin
         n_fail++;
         $display("FAIL rst_mid_bit_count: got %0d expected 5", obs_bits.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (i > 0) n_checks++;
            if (obs_bits[i] !== exp_drive(e, i)) begin
               n_fail++;
               $display("FAIL rst_mid_fall%0d: got %b expected %b", i + 1, obs_bits[i], exp_drive(e, i));
            end
         end
      end
      base = done_count;
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (ps2_clk_drive_low !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clk_drive: got %b expected 0", ps2_clk_drive_low); end
      n_checks++; if (ps2_data_drive_low !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data_drive: got %b expected 0", ps2_data_drive_low); end
      n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx_ready: got %b expected 1", tx_ready); end
      rst = 1'b0;
      dev_clk = 1'b1;
      repeat (60) @(negedge clk);
      n_checks++; if (done_count != base) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_count - base); end
      done_q.delete();
      $display("reset mid-frame checked");
   endtask

   task automatic test_back_to_back;
      logic [7:0] e;
      logic [1:0] f;
      int guard;
      tx_data = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      exp_q.push_back(8'h55);
      tx_data = 8'hAA;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      fork
         device_frame(1'b1, 0, 11);
         begin
            wg = 0;
            while (tx_done !== 1'b1 && wg < 3000) begin @(negedge clk); wg++; end
            @(negedge clk);
            n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_after_done: tx_ready got %b expected 1", tx_ready); end
            @(negedge clk);
            n_checks++; if (busy !== 1'b1 || ps2_clk_drive_low !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: busy=%b clk_drive=%b expected 1 1", busy, ps2_clk_drive_low); end
            exp_q.push_back(8'hAA);
            tx_valid = 1'b0;
         end
      join
      e = exp_q.pop_front();
      n_checks++;
      if (obs_bits.size() != 10) begin
         n_fail++;
         $display("FAIL b2b_first_bit_count: got %0d expected 10", obs_bits.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (i > 0) n_checks++;
            if (obs_bits[i] !== exp_drive(e, i)) begin
               n_fail++;
               $display("FAIL b2b_first_fall%0d: got %b expected %b", i + 1, obs_bits[i], exp_drive(e, i));
            end
         end
      end
      n_checks++;
      if (done_q.size() == 0) begin
         n_fail++;
         $display("FAIL b2b_first_done: got no tx_done expected one");
      end else begin
         f = done_q.pop_front();
         n_checks++; if (f !== 2'b00) begin n_fail++; $display("FAIL b2b_first_flags: got %b expected 00", f); end
      end
      device_frame(1'b1, 0, 11);
      n_checks++; if (dev_inh_len != INH) begin n_fail++; $display("FAIL b2b_second_inhibit: got %0d expected %0d", dev_inh_len, INH); end
      e = exp_q.pop_front();
      n_checks++;
      if (obs_bits.size() != 10) begin
         n_fail++;
         $display("FAIL b2b_second_bit_count: got %0d expected 10", obs_bits.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (i > 0) n_checks++;
            if (obs_bits[i] !== exp_drive(e, i)) begin
               n_fail++;
               $display("FAIL b2b_second_fall%0d: got %b expected %b", i + 1, obs_bits[i], exp_drive(e, i));
            end
         end
      end
      guard = 0;
      while (done_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
      n_checks++;
      if (done_q.size() == 0) begin
         n_fail++;
         $display("FAIL b2b_second_done: got no tx_done expected one");
      end else begin
         f = done_q.pop_front();
         n_checks++; if (f !== 2'b00) begin n_fail++; $display("FAIL b2b_second_flags: got %b expected 00", f); end
      end
      $display("back-to-back 55/AA checked");
   endtask

   initial begin
      test_reset;
      test_frame(8'hED, 1'b1, 0, "ed_ack");
      test_frame(8'h01, 1'b1, 0, "x01_ack");
      test_frame(8'hFF, 1'b0, 0, "ff_nack");
      test_start_timeout;
      test_frame(8'hA3, 1'b1, 3, "glitch");
      test_reset_mid_frame;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes such as 0xED (set LEDs), 0xFF (reset) and 0xF3 (typematic) to the keyboard over the same open-drain clock and data lines that the keyboard receive path listens on. It implements inhibit, request-to-send, device-clocked serialisation with odd parity, and acknowledge sampling, with timeouts. It sits beside the keyboard receive path. Its busy output lets the top level ignore bus activity during a transmission.

Parameters:
INHIBIT_CYCLES, 5000, cycles the clock line is held low before request-to-send (100 us at 50 MHz).
START_TIMEOUT_CYCLES, 750000, maximum cycles from clock release to the first device falling edge (15 ms).
XFER_TIMEOUT_CYCLES, 100000, maximum cycles from the first falling edge to ack sampled (2 ms).
FILTER_CYCLES, 8, consecutive identical synchronised samples required before the filtered ps2_clk changes.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
tx_data  in  8  byte to send.
tx_valid  in  1  request; accepted only in a cycle where tx_valid and tx_ready are both 1.
tx_ready  out  1  1 only in IDLE.
busy  out  1  1 in every state except IDLE.
ps2_clk_in  in  1  raw PS/2 clock pin (asynchronous).
ps2_data_in  in  1  raw PS/2 data pin (asynchronous).
ps2_clk_drive_low  out  1  1 = pull the clock line low; 0 = release.
ps2_data_drive_low  out  1  1 = pull the data line low; 0 = release.
tx_done  out  1  one-cycle pulse when a transaction ends, on success or error.
tx_ack_err  out  1  valid with tx_done; 1 = device did not ack (data line high at ack).
tx_timeout  out  1  valid with tx_done; 1 = a start or transfer timeout occurred.

Behaviour:
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - Synchronised clock is filtered: the filtered value changes only after FILTER_CYCLES equal consecutive samples. Filtered value resets to 1.
  - fall = filtered clock transitions 1 to 0 (one-cycle strobe).
- Reset values: state IDLE, both drive_low outputs 0, tx_done/tx_ack_err/tx_timeout 0, tx_ready 1, busy 0.
- Reset mid-transaction releases both lines on the next clock edge. No tx_done is generated.
- On accept: latch shift register = {1'b1 stop, parity, tx_data[7:0]}, sent LSB first. parity = ~^tx_data, giving odd parity over data plus parity.
- IDLE:
  - tx_ready=1; both lines released.
  - Accept moves to INHIBIT next cycle.
- INHIBIT:
  - clk_drive_low=1; counter counts INHIBIT_CYCLES.
  - In the final inhibit cycle, data_drive_low=1 (start bit, data falls while clock is still low).
  - Then go to SEND with clk_drive_low=0 and data_drive_low held at 1.
- SEND:
  - Bit index starts at 0; START timer runs until the first fall.
  - On each fall, data_drive_low = ~shift[idx], then idx increments.
  - Falls 1-8 carry data bits, fall 9 carries parity, fall 10 carries stop (data released).
  - After the 10th fall, go to ACK.
  - The XFER timer starts at the first fall and keeps running through ACK.
- ACK:
  - data_drive_low=0.
  - On the next fall (the 11th), sample synchronised data: 0 = ack OK, 1 = ack_err.
  - Then go to RELEASE.
- RELEASE: wait until the filtered clock and the synchronised data are both 1, then go to DONE.
- DONE:
  - One cycle; tx_done=1 with the error flags; then IDLE.
  - tx_valid during DONE is not accepted; accept happens in IDLE the following cycle at the earliest.
- Timeouts:
  - START expiry (counter == START_TIMEOUT_CYCLES without a fall) or XFER expiry in SEND or ACK: release both lines immediately.
  - Go to DONE with tx_timeout=1 and tx_ack_err=0.
  - RELEASE has no timeout.
- Flags tx_ack_err and tx_timeout are 0 whenever tx_done is 0.
- Glitches shorter than FILTER_CYCLES on ps2_clk_in produce no fall and do not advance the bit index.
- tx_valid asserted while busy is ignored; no queuing.

Test Plan:
Use sim overrides INHIBIT_CYCLES=20, START_TIMEOUT_CYCLES=400, XFER_TIMEOUT_CYCLES=2000, FILTER_CYCLES=2; the device model clocks with a 40-cycle period.
- Send 0xED, device acks -> clk_drive_low high for 20 cycles; data_drive_low on falls 1-10 = 0,1,0,0,1,0,0,0,0,0 (parity 1); one tx_done with ack_err=0, timeout=0.
- Send 0x01, device acks -> bits LSB-first 1,0,0,0,0,0,0,0, parity 0 (data_drive_low=1 on fall 9), stop released.
- Send 0xFF, device leaves data high at fall 11 -> tx_done with tx_ack_err=1, tx_timeout=0.
- Device never clocks -> 400 cycles after clock release, both lines released and tx_done with tx_timeout=1.
- A 1-cycle low glitch on ps2_clk_in during SEND produces no bit advance; the frame still completes with correct bits. Assert rst at fall 5 -> both drive_low outputs 0 next cycle, tx_ready=1, no tx_done.
- tx_valid held high with 0x55 then 0xAA -> only 0x55 is sent while busy; 0xAA is accepted in the first IDLE cycle after tx_done.
